// File: rtl/bcd_to_bin.sv
// Digit-serial packed-BCD to binary converter, most-significant digit first.
// One digit per clock; start/busy/done framing; nibbles above 9 raise err.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for start; outputs hold the last result
//   CONV  | folding one digit per edge into acc (acc*10 + digit)
module bcd_to_bin #(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err
);

  localparam int SR_W  = 4 * DIGITS;
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic [BIN_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_acc_q, err_acc_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic              err_q, err_d;

  logic [3:0]        nib;
  logic [BIN_W-1:0]  acc_x8, acc_x2, acc_next;
  logic              err_next;

  // acc*10 as shift-and-add, truncated to BIN_W
  always_comb begin
    nib      = sr_q[SR_W-1 -: 4];
    acc_x8   = acc_q << 3;
    acc_x2   = acc_q << 1;
    acc_next = acc_x8 + acc_x2 + BIN_W'(nib);
    err_next = err_acc_q | (nib > 4'd9);
  end

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    err_acc_d = err_acc_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    bin_d     = bin_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sr_d      = bcd_in;
          acc_d     = '0;
          cnt_d     = '0;
          err_acc_d = 1'b0;
          busy_d    = 1'b1;
          state_d   = CONV;
        end
      end
      CONV: begin
        acc_d     = acc_next;
        err_acc_d = err_next;
        sr_d      = sr_q << 4;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          // invalid words still ran through the arithmetic; report zero
          bin_d   = err_next ? '0 : acc_next;
          err_d   = err_next;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      err_acc_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bin_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      err_acc_q <= err_acc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bin_q     <= bin_d;
      err_q     <= err_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bin_out = bin_q;
  assign err     = err_q;

endmodule

// File: doc/bcd_to_bin.md
# bcd_to_bin

Sequential packed-BCD to binary converter, the inverse of the clock datapath's binary-to-BCD stage. Takes a DIGITS-digit BCD word (default two digits, 00–99, e.g. a minute or second field entered via keypad or set buttons) and returns its binary value. Conversion is digit-serial, most-significant digit first, one digit per clock. A start/busy/done handshake frames each conversion. Invalid nibbles (>9) are flagged.

## Interface
- DIGITS, 2, number of BCD digits in bcd_in (≥1)
- BIN_W, 7, width of bin_out; must satisfy 2^BIN_W ≥ 10^DIGITS (2→7, 3→10, 4→14)
- clk  input  1  system clock, all state changes on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request conversion of bcd_in; sampled only in IDLE
- bcd_in  input  4*DIGITS  packed BCD, digit DIGITS-1 in bits [4*DIGITS-1 -: 4]; captured on the accepting edge, may change afterwards
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse, result valid
- bin_out  output  BIN_W  converted value; holds until next done
- err  output  1  qualified by done; 1 = at least one nibble >9 in the captured word; holds until next done

## Operation
- States: IDLE, CONV. Reset → IDLE.
- IDLE, start=1 at an edge: shift register ← bcd_in, acc ← 0, digit counter ← 0, err_acc ← 0, busy ← 1, state ← CONV. start=0: remain IDLE.
- CONV, each edge: d = top nibble of shift register; acc ← acc*10 + d, computed as (acc<<3)+(acc<<1)+d, truncated to BIN_W bits; err_acc ← err_acc | (d>9); shift register ← shift left by 4; counter ← counter+1.
- On the edge processing the last digit (counter = DIGITS-1): bin_out ← (err_acc_next ? 0 : acc_next), err ← err_acc_next, done ← 1, busy ← 0, state ← IDLE.
- Invalid nibbles still feed the arithmetic internally, but the reported bin_out is forced to 0 whenever err=1.
- With BIN_W sized per the rule above, valid input never overflows. No saturation logic is required.
- start while busy: ignored, with no queueing and no effect on the running conversion.
- done is cleared on the edge following its assertion, unless that edge ends another conversion, which is impossible for DIGITS ≥ 1 since a new conversion takes DIGITS edges.

## Timing
- Reset values: busy=0, done=0, bin_out=0, err=0, all internal state 0, state IDLE.
- Reset asserted mid-conversion: immediate abort, outputs return to reset values, no done pulse. Conversion restarts only on a fresh start after release.
- Latency: start sampled at edge k. busy is high from after edge k until edge k+DIGITS. done and the new bin_out/err are visible after edge k+DIGITS. done falls at edge k+DIGITS+1.
- Throughput: start may be high during the done cycle. It is accepted at edge k+DIGITS+1 (state already IDLE), so back-to-back conversions take DIGITS+1 cycles each.
- start held continuously: a new conversion begins every DIGITS+1 cycles.
- bin_out and err change only on a done edge or on reset.

## Test plan
- Defaults, bcd_in=0x42, one-cycle start → busy high 2 cycles, then done pulse 1 cycle with bin_out=42 (0x2A), err=0. Boundary words: 0x00 → 0, 0x99 → 99.
- bcd_in=0x3A and, separately, 0xF1 → done after 2 cycles with err=1, bin_out=0. Follow with 0x17 → bin_out=17, err=0 (err clears).
- Pulse start with 0x25, then hold start high with bcd_in=0x88 while busy → first done gives 25, ignoring the 0x88 request during busy. The 0x88 request is accepted in the done cycle, and the second done gives 88 exactly 3 cycles after the first.
- Start 0x56, change bcd_in to 0x11 the cycle after acceptance → bin_out=56.
- Start 0x73, assert rst_n=0 one cycle later → outputs go to 0 asynchronously, with no done pulse before or after release.
- DIGITS=4, BIN_W=14: 0x9999 → 9999 after 4 cycles; 0x0100 → 100; 0x12C4 → err=1, bin_out=0.
